// File: rtl/aes_key_sched_seq.sv
// ============================================================================
// Module   : aes_key_sched_seq (with aes_sbox cell)
// Purpose  : Flow-controlled AES-128 key schedule, one round key per beat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0 as required.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign o_out = sbox_f(i_in);
endmodule

module aes_key_sched_seq #(
    parameter int NUM_RK    = 11,
    parameter int SBOX_INST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);
    generate
        if (NUM_RK != 11) begin : g_bad_num_rk
            $error("aes_key_sched_seq: NUM_RK must be 11");
        end
        if (SBOX_INST != 4) begin : g_bad_sbox_inst
            $error("aes_key_sched_seq: SBOX_INST must be 4");
        end
    endgenerate

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_RK - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_rk;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_key_ready;
    logic         w_rk_valid;
    logic         w_key_acc;
    logic         w_rk_acc;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_w0n;
    logic [31:0]  w_w1n;
    logic [31:0]  w_w2n;
    logic [31:0]  w_w3n;
    logic [7:0]   w_rcon_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_key_ready = 1'b0;
        w_rk_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_key_ready = 1'b1;
                if (key_valid) w_state_nxt = EMIT;
            end
            EMIT: begin
                w_rk_valid = 1'b1;
                if (rk_ready && (r_idx == c_LAST_IDX)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_key_acc = key_valid & w_key_ready;
    assign w_rk_acc  = w_rk_valid & rk_ready;

    // RotWord of w3, then SubWord through one S-box per byte.
    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_in  (w_rot[8*gi +: 8]),
                .o_out (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t        = w_sub ^ {r_rcon, 24'h000000};
    assign w_w0n      = r_rk[127:96] ^ w_t;
    assign w_w1n      = r_rk[95:64]  ^ w_w0n;
    assign w_w2n      = r_rk[63:32]  ^ w_w1n;
    assign w_w3n      = r_rk[31:0]   ^ w_w2n;
    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rk    <= 128'h0;
            r_idx   <= 4'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            if (w_key_acc) begin
                r_rk   <= key_in;
                r_idx  <= 4'd0;
                r_rcon <= 8'h01;
            end else if (w_rk_acc) begin
                if (r_idx != c_LAST_IDX) begin
                    r_rk   <= {w_w0n, w_w1n, w_w2n, w_w3n};
                    r_idx  <= r_idx + 4'd1;
                    r_rcon <= w_rcon_nxt;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign key_ready = w_key_ready;
    assign rk_valid  = w_rk_valid;
    assign rk_data   = r_rk;
    assign rk_idx    = r_idx;
    assign done      = r_done;
endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_seq.sv
// ============================================================================
// Module   : tb_aes_key_sched_seq
// Purpose  : Scoreboard bench for the AES-128 key schedule sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_key_sched_seq;
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [79:0]  RCON_TAB = 80'h01020408102040801b36;
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key_in = 128'h0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         done;

    aes_key_sched_seq #(.NUM_RK(11), .SBOX_INST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } sb_t;

    sb_t          sb_q[$];
    logic [127:0] seen [0:10];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    bit           nxt_done = 1'b0;
    bit           m_idle;
    bit           m_exp_done;
    sb_t          m_ent;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sbox_b(input logic [7:0] b);
        return SBOX_TAB[2047 - 8*int'(b) -: 8];
    endfunction

    task automatic push_sched(input logic [127:0] key);
        logic [31:0] w0, w1, w2, w3, rw, t;
        sb_t e;
        {w0, w1, w2, w3} = key;
        for (int r = 0; r < 11; r++) begin
            e.idx  = 4'(r);
            e.data = {w0, w1, w2, w3};
            sb_q.push_back(e);
            if (r < 10) begin
                rw = {w3[23:0], w3[31:24]};
                t  = {sbox_b(rw[31:24]), sbox_b(rw[23:16]), sbox_b(rw[15:8]), sbox_b(rw[7:0])};
                t  = t ^ {RCON_TAB[79 - 8*r -: 8], 24'h000000};
                w0 = w0 ^ t;
                w1 = w1 ^ w0;
                w2 = w2 ^ w1;
                w3 = w3 ^ w2;
            end
        end
    endtask

    // Output monitor: handshake expectations follow the scoreboard occupancy.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            nxt_done = 1'b0;
        end else begin
            m_idle     = (sb_q.size() == 0);
            m_exp_done = nxt_done;
            nxt_done   = 1'b0;
            check_val("done", done, m_exp_done);
            check_val("rk_valid", rk_valid, !m_idle);
            check_val("key_ready", key_ready, m_idle);
            if (!m_idle) begin
                check_val("rk_data", rk_data, sb_q[0].data);
                check_val("rk_idx", rk_idx, sb_q[0].idx);
                if (rk_ready) begin
                    m_ent = sb_q.pop_front();
                    seen[m_ent.idx] = rk_data;
                    if (m_ent.idx == 4'd10) nxt_done = 1'b1;
                end
            end
            if (m_idle && key_valid) push_sched(key_in);
        end
    end

    task automatic clear_seen();
        for (int i = 0; i < 11; i++) seen[i] = 128'h0;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        bit got;
        got = 1'b0;
        dc  = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dc  = cyc;
            end
        end
        check_val(tag, got, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int  acc, dc, stall_left;
        bit  stalled, got;
        clear_seen();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle noise: monitor checks rk_valid/done low and key_ready high.
        repeat (20) @(posedge clk);
        #1;

        // FIPS-197 key, full throughput
        rk_ready = 1'b1;
        acc = cyc;
        load_key(FIPS_KEY);
        wait_done("t1_done_seen", dc);
        check_val("t1_done_latency", 32'(dc - acc), 32'd12);
        check_val("t1_rk0", seen[0], FIPS_KEY);
        check_val("t1_rk1", seen[1], FIPS_RK1);
        check_val("t1_rk10", seen[10], FIPS_RK10);

        // All-zero key
        clear_seen();
        load_key(128'h0);
        wait_done("t2_done_seen", dc);
        check_val("t2_rk1", seen[1], ZERO_RK1);
        check_val("t2_rk10", seen[10], ZERO_RK10);

        // Back-pressure with a 5-cycle stall at rk_idx 3
        clear_seen();
        stalled = 1'b0;
        stall_left = 0;
        got = 1'b0;
        load_key(FIPS_KEY);
        for (int c = 0; c < 400 && !got; c++) begin
            if (done) begin
                got = 1'b1;
            end else if (stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else if (!stalled && rk_valid && rk_idx == 4'd3) begin
                stalled = 1'b1;
                stall_left = 4;
                rk_ready = 1'b0;
            end else begin
                rk_ready = 1'($urandom_range(0, 1));
            end
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check_val("t3_done_seen", got, 1'b1);
        check_val("t3_stall_hit", stalled, 1'b1);
        check_val("t3_rk1", seen[1], FIPS_RK1);
        check_val("t3_rk10", seen[10], FIPS_RK10);
        rk_ready = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: second (zero) key held valid through the first run
        clear_seen();
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_in = 128'h0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check_val("t4_first_done", got, 1'b1);
        check_val("t4_first_rk10", seen[10], FIPS_RK10);
        @(posedge clk); #1;
        key_valid = 1'b0;
        check_val("t4_second_rk0", rk_data, 128'h0);
        wait_done("t4_second_done", dc);
        check_val("t4_second_rk1", seen[1], ZERO_RK1);
        check_val("t4_second_rk10", seen[10], ZERO_RK10);

        // Reset mid-expansion at rk_idx 6
        load_key(FIPS_KEY);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rk_idx == 4'd6 && rk_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check_val("t5_reached_idx6", got, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("t5_rk_valid", rk_valid, 1'b0);
        check_val("t5_rk_idx", rk_idx, 4'd0);
        check_val("t5_key_ready", key_ready, 1'b1);
        check_val("t5_done", done, 1'b0);
        check_val("t5_rk_data", rk_data, 128'h0);
        @(posedge clk); #1;
        clear_seen();
        load_key(FIPS_KEY);
        wait_done("t5_done_seen", dc);
        check_val("t5_rk1", seen[1], FIPS_RK1);
        check_val("t5_rk10", seen[10], FIPS_RK10);

        repeat (3) @(posedge clk);
        check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
